// File: rtl/sata_crc_checker_stat.sv
// Rx-path SATA frame CRC checker: residue and length check, optional CRC strip,
// per-frame status pulse and saturating good/CRC-error/length-error counters.
module sata_crc_checker_stat #(
  parameter bit STRIP_CRC = 1'b1,
  parameter int MIN_LEN   = 2,
  parameter int MAX_LEN   = 2050,
  parameter int LENWIDTH  = 12,
  parameter int CNTWIDTH  = 16
) (
  input  logic                reset,
  input  logic                clk,
  input  logic [31:0]         i_dat,
  input  logic                i_val,
  input  logic                i_eop,
  output logic                i_rdy,
  output logic [31:0]         o_dat,
  output logic                o_val,
  output logic                o_eop,
  output logic                o_err,
  input  logic                o_rdy,
  output logic                stat_vld,
  output logic                stat_crc_err,
  output logic                stat_len_err,
  output logic [LENWIDTH-1:0] stat_len,
  input  logic                cnt_clr,
  output logic [CNTWIDTH-1:0] cnt_good,
  output logic [CNTWIDTH-1:0] cnt_crc,
  output logic [CNTWIDTH-1:0] cnt_len
);

  // SATA link-layer CRC: non-reflected, no final inversion, so data+CRC leaves a zero residue.
  localparam logic [31:0] CRC_POLYNOMIAL = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INITVALUE  = 32'h5232_5032;

  localparam logic [LENWIDTH-1:0] MIN_L = LENWIDTH'(MIN_LEN);
  localparam logic [LENWIDTH-1:0] MAX_L = LENWIDTH'(MAX_LEN);

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] d);
    logic [31:0] c;
    // NOTE: blocking '=' is right here: c is a loop temporary, not clocked state.
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? CRC_POLYNOMIAL : 32'h0);
    end
    return c;
  endfunction

  function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [31:0]         crc_q;
  logic [31:0]         crc_new;
  logic [LENWIDTH-1:0] len_q;
  logic [LENWIDTH-1:0] len_next;
  logic                accept;
  logic                last;
  logic                crc_err;
  logic                len_err;
  logic                frame_err;

  assign accept    = i_val & i_rdy;
  assign last      = accept & i_eop;
  assign crc_new   = crc_step(crc_q, i_dat);
  assign len_next  = (&len_q) ? len_q : len_q + 1'b1;
  assign crc_err   = |crc_new;
  assign len_err   = (len_next < MIN_L) | (len_next > MAX_L);
  assign frame_err = crc_err | len_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= CRC_INITVALUE;
      len_q <= '0;
    end else if (accept) begin
      if (i_eop) begin
        crc_q <= CRC_INITVALUE;
        len_q <= '0;
      end else begin
        crc_q <= crc_new;
        len_q <= len_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_vld     <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_len_err <= 1'b0;
      stat_len     <= '0;
    end else begin
      stat_vld <= last;
      if (last) begin
        stat_crc_err <= crc_err;
        stat_len_err <= len_err;
        stat_len     <= len_next;
      end
    end
  end

  // Clear wins over a coinciding frame update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_good <= '0;
      cnt_crc  <= '0;
      cnt_len  <= '0;
    end else if (cnt_clr) begin
      cnt_good <= '0;
      cnt_crc  <= '0;
      cnt_len  <= '0;
    end else if (last) begin
      if (!frame_err) cnt_good <= sat_inc(cnt_good);
      if (crc_err)    cnt_crc  <= sat_inc(cnt_crc);
      if (len_err)    cnt_len  <= sat_inc(cnt_len);
    end
  end

  generate
    if (STRIP_CRC) begin : g_strip
      // One-dword skid: a payload dword is released only once the next beat shows up,
      // which is when we learn whether it was the last payload dword.
      logic        hv;
      logic [31:0] dat_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hv      <= 1'b0;
          dat_reg <= '0;
        end else if (accept) begin
          if (i_eop) begin
            hv <= 1'b0;
          end else begin
            hv      <= 1'b1;
            dat_reg <= i_dat;
          end
        end
      end

      assign i_rdy = ~hv | o_rdy;
      assign o_dat = dat_reg;
      assign o_val = hv & i_val;
      assign o_eop = hv & i_eop;
      assign o_err = hv & i_eop & frame_err;
    end else begin : g_pass
      assign i_rdy = o_rdy;
      assign o_dat = i_dat;
      assign o_val = i_val;
      assign o_eop = i_eop;
      assign o_err = i_eop & frame_err;
    end
  endgenerate

endmodule

// File: tb/tb_sata_crc_checker_stat.sv
// Bench for sata_crc_checker_stat: strip and pass-through instances driven in turn,
// checked against a frame-level model (polynomial-division CRC, queued expectations).
module tb_sata_crc_checker_stat;

  localparam int LW   = 4;
  localparam int CW   = 2;
  localparam int MINL = 2;
  localparam int MAXL = 4;
  localparam int LSAT = (1 << LW) - 1;
  localparam int CSAT = (1 << CW) - 1;
  localparam logic [31:0] INIT      = 32'h5232_5032;
  localparam logic [63:0] POLY_FULL = 64'h1_04C1_1DB7;

  typedef struct { logic [31:0] dat; logic eop; } beat_t;
  typedef struct { logic [31:0] dat; logic eop; logic err; } obeat_t;
  typedef struct { logic crc_err; logic len_err; logic [LW-1:0] len; } stat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0][31:0] i_dat = '0;
  logic [1:0]       i_val = '0;
  logic [1:0]       i_eop = '0;
  logic [1:0]       o_rdy = '1;
  logic [1:0]       cnt_clr = '0;
  wire  [1:0]       i_rdy, o_val, o_eop, o_err, stat_vld, stat_crc_err, stat_len_err;
  wire  [1:0][31:0] o_dat;
  wire  [1:0][LW-1:0] stat_len;
  wire  [1:0][CW-1:0] cnt_good, cnt_crc, cnt_len;

  always #5 clk = ~clk;

  sata_crc_checker_stat #(.STRIP_CRC(1'b1), .MIN_LEN(MINL), .MAX_LEN(MAXL),
                          .LENWIDTH(LW), .CNTWIDTH(CW)) dut_strip (
    .reset(reset), .clk(clk), .i_dat(i_dat[0]), .i_val(i_val[0]), .i_eop(i_eop[0]),
    .i_rdy(i_rdy[0]), .o_dat(o_dat[0]), .o_val(o_val[0]), .o_eop(o_eop[0]),
    .o_err(o_err[0]), .o_rdy(o_rdy[0]), .stat_vld(stat_vld[0]),
    .stat_crc_err(stat_crc_err[0]), .stat_len_err(stat_len_err[0]), .stat_len(stat_len[0]),
    .cnt_clr(cnt_clr[0]), .cnt_good(cnt_good[0]), .cnt_crc(cnt_crc[0]), .cnt_len(cnt_len[0]));

  sata_crc_checker_stat #(.STRIP_CRC(1'b0), .MIN_LEN(MINL), .MAX_LEN(MAXL),
                          .LENWIDTH(LW), .CNTWIDTH(CW)) dut_pass (
    .reset(reset), .clk(clk), .i_dat(i_dat[1]), .i_val(i_val[1]), .i_eop(i_eop[1]),
    .i_rdy(i_rdy[1]), .o_dat(o_dat[1]), .o_val(o_val[1]), .o_eop(o_eop[1]),
    .o_err(o_err[1]), .o_rdy(o_rdy[1]), .stat_vld(stat_vld[1]),
    .stat_crc_err(stat_crc_err[1]), .stat_len_err(stat_len_err[1]), .stat_len(stat_len[1]),
    .cnt_clr(cnt_clr[1]), .cnt_good(cnt_good[1]), .cnt_crc(cnt_crc[1]), .cnt_len(cnt_len[1]));

  int nvec = 0;
  int nmis = 0;
  int cur = 0;
  bit strip = 1'b1;
  int val_pct = 100;
  int rdy_pct = 100;
  int clr_mode = 0;
  int cyc = 0;
  int ov_count = 0;

  bit holding;
  bit stat_pend;
  int cg, cc, cl;
  beat_t  beat_q[$];
  obeat_t exp_q[$];
  stat_t  stat_q[$];
  stat_t  done_q[$];
  logic [31:0] pay[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0t)", tag, act, exp, cur, $time);
    end
  endtask

  // Remainder of (c ^ d) * x^32 divided by the generator, by long division.
  function automatic logic [31:0] crc_res(input logic [31:0] c, input logic [31:0] d);
    logic [63:0] r;
    r = {c ^ d, 32'h0};
    for (int b = 63; b >= 32; b--) if (r[b]) r = r ^ (POLY_FULL << (b - 32));
    return r[31:0];
  endfunction

  function automatic int sat(input int c);
    return (c >= CSAT) ? CSAT : c + 1;
  endfunction

  task automatic model_reset();
    holding = 1'b0;
    stat_pend = 1'b0;
    cg = 0; cc = 0; cl = 0;
    beat_q.delete(); exp_q.delete(); stat_q.delete(); done_q.delete();
  endtask

  // Queue one frame: payload from pay[], CRC dword XOR flip.
  task automatic enqueue_frame(input logic [31:0] flip);
    logic [31:0] c, r;
    beat_t fb[$];
    obeat_t o;
    stat_t s;
    int l, ls, n;
    bit ce, le;
    c = INIT;
    foreach (pay[i]) c = crc_res(c, pay[i]);
    foreach (pay[i]) fb.push_back('{dat: pay[i], eop: 1'b0});
    fb.push_back('{dat: c ^ flip, eop: 1'b1});
    r = INIT;
    foreach (fb[i]) r = crc_res(r, fb[i].dat);
    ce = (r != 32'h0);
    l  = fb.size();
    ls = (l > LSAT) ? LSAT : l;
    le = (ls < MINL) || (ls > MAXL);
    s = '{crc_err: ce, len_err: le, len: LW'(ls)};
    stat_q.push_back(s);
    done_q.push_back(s);
    n = strip ? pay.size() : fb.size();
    for (int i = 0; i < n; i++) begin
      o = '{dat: fb[i].dat, eop: (i == n - 1), err: (i == n - 1) && (ce || le)};
      exp_q.push_back(o);
    end
    foreach (fb[i]) beat_q.push_back(fb[i]);
    pay.delete();
  endtask

  task automatic cycle();
    bit drive, exp_rdy, is_eop;
    obeat_t e;
    stat_t s;
    beat_t b;
    @(negedge clk);
    cyc++;
    drive  = (beat_q.size() > 0) && ($urandom_range(99) < val_pct);
    is_eop = drive && beat_q[0].eop;
    i_val[cur] = drive;
    i_dat[cur] = drive ? beat_q[0].dat : $urandom;
    i_eop[cur] = is_eop;
    o_rdy[cur] = ($urandom_range(99) < rdy_pct);
    cnt_clr[cur] = (clr_mode == 1) ? ($urandom_range(99) < 5) : (clr_mode == 2 && is_eop);
    #3;
    exp_rdy = strip ? (!holding || o_rdy[cur]) : o_rdy[cur];
    check("i_rdy", 32'(i_rdy[cur]), 32'(exp_rdy));
    if (o_val[cur]) ov_count++;
    if (o_val[cur] && o_rdy[cur]) begin
      if (exp_q.size() == 0) begin
        check("o_val_extra", 32'(o_val[cur]), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("o_dat", o_dat[cur], e.dat);
        check("o_eop", 32'(o_eop[cur]), 32'(e.eop));
        check("o_err", 32'(o_err[cur]), 32'(e.err));
      end
    end
    check("stat_vld", 32'(stat_vld[cur]), 32'(stat_pend));
    if (stat_pend && stat_q.size() > 0) begin
      s = stat_q.pop_front();
      check("stat_crc_err", 32'(stat_crc_err[cur]), 32'(s.crc_err));
      check("stat_len_err", 32'(stat_len_err[cur]), 32'(s.len_err));
      check("stat_len", 32'(stat_len[cur]), 32'(s.len));
    end
    check("cnt_good", 32'(cnt_good[cur]), 32'(cg));
    check("cnt_crc", 32'(cnt_crc[cur]), 32'(cc));
    check("cnt_len", 32'(cnt_len[cur]), 32'(cl));
    // Advance the model across the coming edge.
    stat_pend = 1'b0;
    if (cnt_clr[cur]) begin
      cg = 0; cc = 0; cl = 0;
    end
    if (drive && exp_rdy) begin
      b = beat_q.pop_front();
      if (b.eop) begin
        holding = 1'b0;
        stat_pend = 1'b1;
        if (done_q.size() > 0) begin
          s = done_q.pop_front();
          if (!cnt_clr[cur]) begin
            if (!s.crc_err && !s.len_err) cg = sat(cg);
            if (s.crc_err) cc = sat(cc);
            if (s.len_err) cl = sat(cl);
          end
        end
      end else begin
        holding = 1'b1;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((beat_q.size() > 0 || exp_q.size() > 0 || stat_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(beat_q.size() + exp_q.size() + stat_q.size()), 32'(0));
    cycle();
    cycle();
  endtask

  task automatic do_reset(input bit mid);
    @(negedge clk);
    reset = 1'b1;
    o_rdy[cur] = 1'b1;
    cnt_clr = '0;
    if (mid && beat_q.size() > 0) begin
      i_val[cur] = 1'b1;
      i_dat[cur] = beat_q[0].dat;
      i_eop[cur] = 1'b0;
    end else begin
      i_val = '0;
      i_eop = '0;
    end
    #3;
    check("rst_i_rdy", 32'(i_rdy[cur]), 32'(1));
    if (strip) begin
      check("rst_o_val", 32'(o_val[cur]), 32'(0));
      check("rst_o_dat", o_dat[cur], 32'h0);
    end
    check("rst_stat_vld", 32'(stat_vld[cur]), 32'(0));
    check("rst_stat_crc", 32'(stat_crc_err[cur]), 32'(0));
    check("rst_stat_lerr", 32'(stat_len_err[cur]), 32'(0));
    check("rst_stat_len", 32'(stat_len[cur]), 32'(0));
    check("rst_cnt_good", 32'(cnt_good[cur]), 32'(0));
    check("rst_cnt_crc", 32'(cnt_crc[cur]), 32'(0));
    check("rst_cnt_len", 32'(cnt_len[cur]), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    i_val = '0;
    i_eop = '0;
    model_reset();
  endtask

  task automatic run_tests();
    int t0;
    val_pct = 100; rdy_pct = 100; clr_mode = 0;
    do_reset(1'b0);

    // Good 3-dword payload.
    pay = '{32'h1, 32'h2, 32'h3};
    enqueue_frame(32'h0);
    drain(50);
    check("t1_stat_len", 32'(stat_len[cur]), 32'(4));
    check("t1_stat_crc", 32'(stat_crc_err[cur]), 32'(0));
    check("t1_cnt_good", 32'(cnt_good[cur]), 32'(1));

    // Same frame, CRC bit 0 flipped.
    pay = '{32'h1, 32'h2, 32'h3};
    enqueue_frame(32'h1);
    drain(50);
    check("t2_stat_crc", 32'(stat_crc_err[cur]), 32'(1));
    check("t2_cnt_crc", 32'(cnt_crc[cur]), 32'(1));
    check("t2_cnt_good", 32'(cnt_good[cur]), 32'(1));

    // Single-dword frame.
    ov_count = 0;
    enqueue_frame(32'h0);
    drain(50);
    check("t3_o_val_count", 32'(ov_count), strip ? 32'(0) : 32'(1));
    check("t3_stat_len", 32'(stat_len[cur]), 32'(1));
    check("t3_stat_lerr", 32'(stat_len_err[cur]), 32'(1));
    check("t3_cnt_len", 32'(cnt_len[cur]), 32'(1));

    // Over-long frame then a good frame back-to-back: 9 beats in 9 cycles.
    for (int i = 0; i < 4; i++) pay.push_back($urandom);
    enqueue_frame(32'h0);
    for (int i = 0; i < 3; i++) pay.push_back($urandom);
    enqueue_frame(32'h0);
    t0 = cyc;
    while (beat_q.size() > 0 && cyc - t0 < 40) cycle();
    check("b2b_cycles", 32'(cyc - t0), 32'(9));
    drain(50);
    check("t4_cnt_len", 32'(cnt_len[cur]), 32'(2));
    check("t4_cnt_good", 32'(cnt_good[cur]), 32'(2));

    // Length-counter saturation on a 20-dword frame.
    for (int i = 0; i < 19; i++) pay.push_back($urandom);
    enqueue_frame(32'h0);
    drain(100);
    check("t5_stat_len", 32'(stat_len[cur]), 32'(LSAT));
    check("t5_stat_lerr", 32'(stat_len_err[cur]), 32'(1));

    // Random frames under throttling with random counter clears.
    val_pct = 70; rdy_pct = 60; clr_mode = 1;
    for (int f = 0; f < 100; f++) begin
      int n;
      n = ($urandom_range(99) < 4) ? 18 : int'($urandom_range(6));
      for (int i = 0; i < n; i++) pay.push_back($urandom);
      enqueue_frame(($urandom_range(99) < 25) ? (32'h1 << $urandom_range(31)) : 32'h0);
    end
    drain(6000);

    // Counter saturation.
    val_pct = 100; rdy_pct = 100; clr_mode = 0;
    for (int f = 0; f < 4; f++) begin
      pay = '{$urandom, $urandom};
      enqueue_frame(32'h0);
    end
    drain(100);
    check("sat_cnt_good", 32'(cnt_good[cur]), 32'(CSAT));

    // Clear coinciding with a CRC-error frame update.
    clr_mode = 2;
    pay = '{$urandom, $urandom};
    enqueue_frame(32'h8000_0000);
    drain(50);
    clr_mode = 0;
    check("clr_cnt_good", 32'(cnt_good[cur]), 32'(0));
    check("clr_cnt_crc", 32'(cnt_crc[cur]), 32'(0));
    check("clr_cnt_len", 32'(cnt_len[cur]), 32'(0));

    // Reset while dword 2 is presented, then a clean frame.
    pay = '{$urandom, $urandom, $urandom, $urandom};
    enqueue_frame(32'h0);
    cycle();
    do_reset(1'b1);
    pay = '{$urandom, $urandom, $urandom};
    enqueue_frame(32'h0);
    drain(50);
    check("rst_after_len", 32'(stat_len[cur]), 32'(4));
    check("rst_after_crc", 32'(stat_crc_err[cur]), 32'(0));
    check("rst_after_good", 32'(cnt_good[cur]), 32'(1));
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < 2; k++) begin
      cur = k;
      strip = (k == 0);
      run_tests();
      i_val = '0;
      i_eop = '0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nvec);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sata_crc_checker_stat.md
Name: sata_crc_checker_stat

Overview:
Second-generation SerialATA frame CRC checker. It sits on the Rx path between the link-layer dword stream and the transport layer. Every frame ends with a CRC dword (eop beat). The block checks the CRC residue and the frame length against configurable limits. It either strips the CRC dword or passes it through, and reports per-frame status plus saturating error/good-frame counters. CRC polynomial and init value come from `CRC_POLYNOMIAL` and `CRC_INITVALUE` in sata_defs.svh; the CRC is computed with crc_calculator (DATAWIDTH 32, CRCWIDTH 32).

Parameters:
STRIP_CRC, 1, 1 = CRC dword removed from output; 0 = CRC dword forwarded as the eop beat
MIN_LEN, 2, minimum legal frame length in dwords, CRC included; must be >= 2 when STRIP_CRC = 1
MAX_LEN, 2050, maximum legal frame length in dwords, CRC included
LENWIDTH, 12, width of length counter and stat_len; must satisfy 2^LENWIDTH - 1 > MAX_LEN
CNTWIDTH, 16, width of each statistics counter

Ports:
reset  in  1  asynchronous reset, active high
clk  in  1  single clock; all logic on rising edge
i_dat  in  32  input dword
i_val  in  1  input valid
i_eop  in  1  input last dword (the CRC dword)
i_rdy  out  1  input ready
o_dat  out  32  output dword
o_val  out  1  output valid
o_eop  out  1  output last beat of frame
o_err  out  1  frame error, qualified by o_val & o_eop
o_rdy  in  1  output ready
stat_vld  out  1  one-cycle per-frame status pulse
stat_crc_err  out  1  CRC residue nonzero, qualified by stat_vld
stat_len_err  out  1  length outside [MIN_LEN, MAX_LEN], qualified by stat_vld
stat_len  out  LENWIDTH  frame length in dwords incl. CRC, qualified by stat_vld
cnt_clr  in  1  synchronous clear of all counters
cnt_good  out  CNTWIDTH  frames with no error
cnt_crc  out  CNTWIDTH  frames with CRC error
cnt_len  out  CNTWIDTH  frames with length error

Behaviour:
- Reset: all registers cleared; crc register = `CRC_INITVALUE`. Outputs: i_rdy = 1, o_val = 0, o_dat = 0, stat_* = 0, counters = 0. Reset mid-frame discards the partial frame; the next accepted beat starts a new frame.
- Accept: an input beat is accepted when i_val & i_rdy. The crc register loads crc_new on an accepted non-eop beat and reloads `CRC_INITVALUE` on an accepted eop beat.
- Length counter: counts accepted beats; saturates at all-ones; clears after the eop beat. Frame length L = count including the eop beat.
- crc_err = (crc_new != 0) on the eop beat; this is a residue check over payload plus CRC dword.
- len_err = (L < MIN_LEN) | (L > MAX_LEN).
- STRIP_CRC = 1:
  - One-dword holding register with flag hv. i_rdy = ~hv | o_rdy.
  - Accepted non-eop beat: dat_reg <= i_dat, hv <= 1. Accepted eop beat: hv <= 0.
  - o_dat = dat_reg; o_val = hv & i_val; o_eop = hv & i_eop; o_err = hv & i_eop & (crc_err | len_err).
  - Output beat n is presented together with input beat n+1; the CRC beat itself is never output.
  - Single-dword frame (eop with hv = 0): no output beat; the status pulse is still generated.
- STRIP_CRC = 0:
  - Pass-through: o_dat = i_dat, o_val = i_val, o_eop = i_eop, i_rdy = o_rdy.
  - o_err = i_eop & (crc_err | len_err).
  - Zero latency; no holding register.
- Status: on the clock edge after an accepted eop beat, stat_vld = 1 for exactly one cycle, with stat_crc_err, stat_len_err and stat_len = L registered. stat_vld = 0 otherwise; the status fields hold their last values.
- Counters: update on the same edge that raises stat_vld.
  - cnt_good += 1 if neither error.
  - cnt_crc += 1 if crc_err; cnt_len += 1 if len_err; a frame with both errors increments both.
  - All counters saturate at all-ones; no wrap.
  - cnt_clr has priority: a frame whose update coincides with cnt_clr is not counted.
- Back-to-back frames (eop followed immediately by the next frame's first beat) must be handled with no bubble.
- Length-counter saturation keeps len_err asserted for arbitrarily long frames.

Test Plan:
- STRIP_CRC = 1, payload 0x00000001, 0x00000002, 0x00000003 plus correct CRC (bench model), o_rdy = 1 -> three output beats, eop on 0x00000003, o_err = 0; stat_vld pulse with stat_len = 4, no errors; cnt_good = 1.
- Same frame with CRC bit 0 flipped -> o_err = 1 on the 0x00000003 beat; stat_crc_err = 1; cnt_crc = 1; cnt_good unchanged.
- Single-dword frame (eop on first beat), STRIP_CRC = 1 -> no o_val; stat_len = 1, stat_len_err = 1; cnt_len = 1.
- MAX_LEN = 4, 5-dword frame with valid CRC -> o_err = 1, stat_len_err = 1, stat_crc_err = 0; then a 4-dword good frame back-to-back -> o_err = 0, no bubble between frames.
- Random o_rdy / i_val throttling over 100 random frames, both STRIP_CRC values -> output equals the model stream; counters match the model; CNTWIDTH = 2 saturates at 3; cnt_clr coincident with stat_vld leaves counters at 0.
- Assert reset in the middle of frame dword 2 -> outputs return to reset values; the following good frame is reported with no error and the correct stat_len.
